// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
// Shares the single SRAM FIFO port between port A (SPI-side slave controller)
// and port B (wireless controller). Accesses are serialised with round-robin
// fairness. A lock input keeps a multi-word frame on one port. Full/empty gate
// which requests may start, and a watchdog aborts an access that the SRAM
// never acknowledges.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   a_read/a_write/a_lock         port A request levels and frame lock
//   a_data_in / a_data_out        port A write data / read data (held)
//   a_hint                        port A one-cycle completion pulse
//   b_*                           same set of signals for port B
//   sram_read/sram_write          strobes to the SRAM FIFO
//   sram_data_to/sram_data_from   write data out / read data in
//   sram_hint                     SRAM acknowledge for the current strobe
//   sram_full/sram_empty          FIFO status, sampled only when arbitrating
//   grant                         one-hot owner: 01 = A, 10 = B, 00 = none
//   timeout_err                   one-cycle pulse on watchdog abort
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | arbitrate; sticky owner only, else round-robin on eligibility
// S_ISSUE   | strobe held, watchdog counting, waiting for sram_hint
// S_RELEASE | waiting for owner to drop its request; decide sticky / release
module sram_port_arbiter #(
   parameter int DW      = 16,
   parameter int TIMEOUT = 255
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          a_read,
   input  logic          a_write,
   input  logic          a_lock,
   input  logic [DW-1:0] a_data_in,
   output logic          a_hint,
   output logic [DW-1:0] a_data_out,
   input  logic          b_read,
   input  logic          b_write,
   input  logic          b_lock,
   input  logic [DW-1:0] b_data_in,
   output logic          b_hint,
   output logic [DW-1:0] b_data_out,
   output logic          sram_read,
   output logic          sram_write,
   output logic [DW-1:0] sram_data_to,
   input  logic [DW-1:0] sram_data_from,
   input  logic          sram_hint,
   input  logic          sram_full,
   input  logic          sram_empty,
   output logic [1:0]    grant,
   output logic          timeout_err
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RELEASE} state_t;

   localparam logic [15:0] TO_CNT = 16'(TIMEOUT);

   state_t        state, state_n;
   logic          sticky_vld, sticky_vld_n;
   logic          sticky_b, sticky_b_n;
   logic          last_b, last_b_n;
   logic          to_flag, to_flag_n;
   logic [15:0]   wdog, wdog_n, wdog_inc;
   logic [1:0]    grant_n;
   logic          sram_read_n, sram_write_n;
   logic [DW-1:0] data_to_n, a_dout_n, b_dout_n;
   logic          a_hint_n, b_hint_n, to_err_n;
   logic          a_elig, b_elig, win_a, win_b;
   logic          own_b, own_req, own_lock;

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         sticky_vld   <= 1'b0;
         sticky_b     <= 1'b0;
         last_b       <= 1'b1;
         to_flag      <= 1'b0;
         wdog         <= '0;
         grant        <= 2'b00;
         sram_read    <= 1'b0;
         sram_write   <= 1'b0;
         sram_data_to <= '0;
         a_data_out   <= '0;
         b_data_out   <= '0;
         a_hint       <= 1'b0;
         b_hint       <= 1'b0;
         timeout_err  <= 1'b0;
      end else begin
         state        <= state_n;
         sticky_vld   <= sticky_vld_n;
         sticky_b     <= sticky_b_n;
         last_b       <= last_b_n;
         to_flag      <= to_flag_n;
         wdog         <= wdog_n;
         grant        <= grant_n;
         sram_read    <= sram_read_n;
         sram_write   <= sram_write_n;
         sram_data_to <= data_to_n;
         a_data_out   <= a_dout_n;
         b_data_out   <= b_dout_n;
         a_hint       <= a_hint_n;
         b_hint       <= b_hint_n;
         timeout_err  <= to_err_n;
      end
   end

   always_comb begin
      // write wins over read, so a full FIFO blocks a port that asserts both
      a_elig = a_write ? ~sram_full : (a_read & ~sram_empty);
      b_elig = b_write ? ~sram_full : (b_read & ~sram_empty);

      win_a = 1'b0;
      win_b = 1'b0;
      if (sticky_vld) begin
         win_a = ~sticky_b & a_elig;
         win_b = sticky_b & b_elig;
      end else if (a_elig && b_elig) begin
         win_a = last_b;
         win_b = ~last_b;
      end else begin
         win_a = a_elig;
         win_b = b_elig;
      end

      own_b    = grant[1];
      own_req  = own_b ? (b_read | b_write) : (a_read | a_write);
      own_lock = own_b ? b_lock : a_lock;
      wdog_inc = wdog + 16'd1;

      state_n      = state;
      sticky_vld_n = sticky_vld;
      sticky_b_n   = sticky_b;
      last_b_n     = last_b;
      to_flag_n    = to_flag;
      wdog_n       = wdog;
      grant_n      = grant;
      sram_read_n  = sram_read;
      sram_write_n = sram_write;
      data_to_n    = sram_data_to;
      a_dout_n     = a_data_out;
      b_dout_n     = b_data_out;
      a_hint_n     = 1'b0;
      b_hint_n     = 1'b0;
      to_err_n     = 1'b0;

      case (state)
         S_IDLE: begin
            if (win_a || win_b) begin
               grant_n      = win_b ? 2'b10 : 2'b01;
               sram_write_n = win_b ? b_write : a_write;
               sram_read_n  = win_b ? (~b_write & b_read) : (~a_write & a_read);
               data_to_n    = win_b ? b_data_in : a_data_in;
               wdog_n       = '0;
               to_flag_n    = 1'b0;
               state_n      = S_ISSUE;
            end
         end
         S_ISSUE: begin
            // wdog_inc is the 1-based count of the current ISSUE cycle
            if (sram_hint) begin
               sram_read_n  = 1'b0;
               sram_write_n = 1'b0;
               if (sram_read) begin
                  if (own_b) b_dout_n = sram_data_from;
                  else       a_dout_n = sram_data_from;
               end
               if (own_b) b_hint_n = 1'b1;
               else       a_hint_n = 1'b1;
               state_n = S_RELEASE;
            end else if (wdog_inc == TO_CNT) begin
               sram_read_n  = 1'b0;
               sram_write_n = 1'b0;
               if (own_b) b_hint_n = 1'b1;
               else       a_hint_n = 1'b1;
               to_err_n     = 1'b1;
               to_flag_n    = 1'b1;
               sticky_vld_n = 1'b0;
               state_n      = S_RELEASE;
            end else begin
               wdog_n = wdog_inc;
            end
         end
         S_RELEASE: begin
            if (!own_req) begin
               if (own_lock && !to_flag) begin
                  sticky_vld_n = 1'b1;
                  sticky_b_n   = own_b;
               end else begin
                  sticky_vld_n = 1'b0;
                  grant_n      = 2'b00;
               end
               last_b_n = own_b;
               state_n  = S_IDLE;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_sram_port_arbiter.sv
module tb_sram_port_arbiter;
   localparam int DW  = 16;
   localparam int TMO = 8;

   logic          clk, rst;
   logic          a_read, a_write, a_lock, a_hint;
   logic [DW-1:0] a_data_in, a_data_out;
   logic          b_read, b_write, b_lock, b_hint;
   logic [DW-1:0] b_data_in, b_data_out;
   logic          sram_read, sram_write, sram_hint, sram_full, sram_empty;
   logic [DW-1:0] sram_data_to, sram_data_from;
   logic [1:0]    grant;
   logic          timeout_err;

   sram_port_arbiter #(.DW(DW), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst),
      .a_read(a_read), .a_write(a_write), .a_lock(a_lock), .a_data_in(a_data_in),
      .a_hint(a_hint), .a_data_out(a_data_out),
      .b_read(b_read), .b_write(b_write), .b_lock(b_lock), .b_data_in(b_data_in),
      .b_hint(b_hint), .b_data_out(b_data_out),
      .sram_read(sram_read), .sram_write(sram_write), .sram_data_to(sram_data_to),
      .sram_data_from(sram_data_from), .sram_hint(sram_hint),
      .sram_full(sram_full), .sram_empty(sram_empty),
      .grant(grant), .timeout_err(timeout_err)
   );

   typedef struct {
      int            port;
      bit            wr;
      logic [DW-1:0] data;
      int            cycles;
      bit            tmo;
   } exp_t;

   exp_t          exp_q[$];
   logic [DW-1:0] mem_q[$];   // contents held by the SRAM model
   logic [DW-1:0] ref_q[$];   // reference FIFO contents in predicted service order
   int            hint_lat;   // strobe cycles before the SRAM acks; 0 = never
   int            checks, errors;
   bit            model_last_b;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "bench time limit");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [1:0] onehot(input int port);
      return (port == 1) ? 2'b10 : 2'b01;
   endfunction

   // Reference model: one access completes per call, in the order given.
   task automatic expect_access(input int port, input bit wr, input logic [DW-1:0] wdata, input bit tmo);
      exp_t e;
      e.port   = port;
      e.wr     = wr;
      e.tmo    = tmo;
      e.cycles = tmo ? TMO : hint_lat;
      if (wr) begin
         e.data = wdata;
         if (!tmo) ref_q.push_back(wdata);
      end else begin
         e.data = (ref_q.size() > 0) ? ref_q.pop_front() : '0;
      end
      exp_q.push_back(e);
      model_last_b = (port == 1);
   endtask

   // SRAM FIFO model
   initial begin
      int cnt;
      cnt = 0;
      sram_hint = 1'b0;
      sram_data_from = '0;
      forever begin
         @(posedge clk);
         #1;
         sram_hint = 1'b0;
         if (rst || !(sram_read || sram_write)) begin
            cnt = 0;
         end else begin
            cnt++;
            if (hint_lat != 0 && cnt == hint_lat) begin
               sram_hint = 1'b1;
               if (sram_write) mem_q.push_back(sram_data_to);
               else sram_data_from = (mem_q.size() > 0) ? mem_q.pop_front() : 16'hDEAD;
            end
         end
      end
   end

   // Monitor: pops one expectation per completion pulse
   initial begin
      bit            strobe_prev, acc_wr;
      logic [DW-1:0] acc_data;
      logic [1:0]    acc_grant;
      int            strobe_len, port;
      exp_t          e;
      strobe_prev = 1'b0; acc_wr = 1'b0; acc_data = '0; acc_grant = '0; strobe_len = 0;
      forever begin
         @(negedge clk);
         if (sram_read || sram_write) begin
            if (!strobe_prev) begin
               acc_wr     = sram_write;
               acc_data   = sram_data_to;
               acc_grant  = grant;
               strobe_len = 0;
            end
            strobe_len++;
         end
         strobe_prev = sram_read || sram_write;
         if (a_hint || b_hint) begin
            port = b_hint ? 1 : 0;
            chk("single_hint", 32'(a_hint & b_hint), 0);
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_hint port=%0d actual=hint required=none", port);
            end else begin
               e = exp_q.pop_front();
               chk("hint_port", port, e.port);
               chk("grant_at_issue", 32'(acc_grant), 32'(onehot(e.port)));
               chk("grant_held", 32'(grant), 32'(onehot(e.port)));
               chk("op_is_write", 32'(acc_wr), 32'(e.wr));
               if (e.wr) chk("write_data", 32'(acc_data), 32'(e.data));
               else      chk("read_data", 32'(port ? b_data_out : a_data_out), 32'(e.data));
               chk("strobe_cycles", strobe_len, e.cycles);
               chk("timeout_err", 32'(timeout_err), 32'(e.tmo));
            end
         end else if (timeout_err) begin
            checks++;
            errors++;
            $display("FAIL stray_timeout_err actual=1 required=0");
         end
      end
   end

   // Requester: raise request, wait for hint, drop request and set lock.
   task automatic access(input int port, input bit wr, input logic [DW-1:0] d, input bit lock_after);
      bit got;
      got = 1'b0;
      @(negedge clk);
      if (port == 0) begin
         a_write = wr; a_read = wr ? 1'($urandom_range(0, 1)) : 1'b1; a_data_in = d;
      end else begin
         b_write = wr; b_read = wr ? 1'($urandom_range(0, 1)) : 1'b1; b_data_in = d;
      end
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if ((port == 0 && a_hint) || (port == 1 && b_hint)) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL wait_hint port=%0d actual=no_hint required=hint", port);
      end
      if (port == 0) begin a_write = 1'b0; a_read = 1'b0; a_lock = lock_after; end
      else           begin b_write = 1'b0; b_read = 1'b0; b_lock = lock_after; end
   endtask

   task automatic drain(input string name);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk);
         if (exp_q.size() == 0) begin ok = 1'b1; break; end
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s actual=%0d_pending required=0_pending", name, exp_q.size());
      end
   endtask

   initial begin
      logic [DW-1:0] w, wa, wb;
      logic [DW-1:0] frame[5];
      int            first, seen, port;
      bit            wr;
      checks = 0; errors = 0;
      rst = 1'b1; hint_lat = 3; model_last_b = 1'b1;
      a_read = 0; a_write = 0; a_lock = 0; a_data_in = '0;
      b_read = 0; b_write = 0; b_lock = 0; b_data_in = '0;
      sram_full = 1'b0; sram_empty = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_grant", 32'(grant), 0);
      chk("rst_strobes", 32'({sram_read, sram_write}), 0);
      chk("rst_pulses", 32'({a_hint, b_hint, timeout_err}), 0);
      chk("rst_data_out", {a_data_out, b_data_out}, 0);
      chk("rst_data_to", 32'(sram_data_to), 0);
      rst = 1'b0;

      // round-robin reads, both ports requesting together
      hint_lat = $urandom_range(1, 6);
      for (int k = 0; k < 4; k++) begin
         w = DW'($urandom);
         mem_q.push_back(w);
         ref_q.push_back(w);
      end
      first = model_last_b ? 0 : 1;
      for (int k = 0; k < 4; k++) expect_access((k % 2 == 0) ? first : 1 - first, 1'b0, '0, 1'b0);
      fork
         begin access(0, 1'b0, '0, 1'b0); access(0, 1'b0, '0, 1'b0); end
         begin access(1, 1'b0, '0, 1'b0); access(1, 1'b0, '0, 1'b0); end
      join
      drain("rr_drain");

      // single A write, 3-cycle acknowledge
      hint_lat = 3;
      expect_access(0, 1'b1, 16'h66A5, 1'b0);
      access(0, 1'b1, 16'h66A5, 1'b0);
      drain("single_drain");
      @(negedge clk);
      chk("grant_idle_after_single", 32'(grant), 0);

      // locked 5-word frame on A while B requests
      hint_lat = $urandom_range(1, 6);
      for (int k = 0; k < 5; k++) frame[k] = DW'($urandom);
      wb = DW'($urandom);
      for (int k = 0; k < 5; k++) expect_access(0, 1'b1, frame[k], 1'b0);
      expect_access(1, 1'b1, wb, 1'b0);
      a_lock = 1'b1;
      fork
         begin for (int k = 0; k < 5; k++) access(0, 1'b1, frame[k], k < 4); end
         begin repeat (3) @(negedge clk); access(1, 1'b1, wb, 1'b0); end
      join
      drain("lock_drain");

      // FIFO full: A write pending, B read served first
      hint_lat = $urandom_range(1, 6);
      sram_full = 1'b1;
      wa = DW'($urandom);
      expect_access(1, 1'b0, '0, 1'b0);
      expect_access(0, 1'b1, wa, 1'b0);
      fork
         access(0, 1'b1, wa, 1'b0);
         begin
            access(1, 1'b0, '0, 1'b0);
            seen = 0;
            repeat (10) begin
               @(negedge clk);
               if (sram_write) seen++;
            end
            chk("no_write_while_full", seen, 0);
            sram_full = 1'b0;
         end
      join
      drain("full_drain");

      // watchdog abort clears sticky even with lock held
      hint_lat = 0;
      a_lock = 1'b1;
      wa = DW'($urandom);
      expect_access(0, 1'b1, wa, 1'b1);
      access(0, 1'b1, wa, 1'b1);
      repeat (2) @(negedge clk);
      chk("timeout_sticky_cleared", 32'(grant), 0);
      hint_lat = $urandom_range(1, 6);
      wb = DW'($urandom);
      expect_access(1, 1'b1, wb, 1'b0);
      access(1, 1'b1, wb, 1'b0);
      drain("timeout_drain");
      a_lock = 1'b0;

      // reset two cycles into ISSUE
      hint_lat = 0;
      @(negedge clk);
      a_read = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (sram_read) break;
      end
      chk("rst_mid_issued", 32'(sram_read), 1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_mid_strobe", 32'({sram_read, sram_write}), 0);
      chk("rst_mid_grant", 32'(grant), 0);
      chk("rst_mid_pulses", 32'({a_hint, b_hint, timeout_err}), 0);
      rst = 1'b0;
      a_read = 1'b0;
      model_last_b = 1'b1;
      repeat (4) @(negedge clk);
      hint_lat = $urandom_range(1, 6);
      expect_access(0, 1'b0, '0, 1'b0);
      expect_access(1, 1'b0, '0, 1'b0);
      fork
         access(0, 1'b0, '0, 1'b0);
         access(1, 1'b0, '0, 1'b0);
      join
      drain("post_rst_drain");

      // random single-requester traffic against the FIFO model
      for (int k = 0; k < 12; k++) begin
         port = $urandom_range(0, 1);
         wr = (ref_q.size() == 0) ? 1'b1 : 1'($urandom_range(0, 1));
         w = DW'($urandom);
         hint_lat = $urandom_range(1, 6);
         expect_access(port, wr, w, 1'b0);
         access(port, wr, w, 1'b0);
         drain("random_drain");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
